fpu_issue_arbiter: RTL and testbench

FPU_ISSUE_ARBITER -- requirements
Module: fpu_issue_arbiter

---
 rtl/fpu_issue_arbiter_if.sv | 61 ++++++
 rtl/fpu_issue_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_arbiter_if
//  Description : Bundles the two requester channels, the shared-FPU issue and
//                result path, the response strobes and status.
//                The master side is the environment: the requesters plus the
//                FPU. The slave side is the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpu_issue_arbiter_if;

    // Requester A
    logic        req_a_valid;
    logic        req_a_ready;
    logic [31:0] req_a_opa;
    logic [31:0] req_a_opb;
    logic        req_a_op;

    // Requester B
    logic        req_b_valid;
    logic        req_b_ready;
    logic [31:0] req_b_opa;
    logic [31:0] req_b_opb;
    logic        req_b_op;

    // Global throttle
    logic        hold;

    // Shared FPU issue and result
    logic        fpu_issue;
    logic [31:0] fpu_opa;
    logic [31:0] fpu_opb;
    logic        fpu_op;
    logic [31:0] fpu_result;

    // Responses and status
    logic        rsp_a_valid;
    logic        rsp_b_valid;
    logic [31:0] rsp_data;
    logic        idle;

    modport master (
        output req_a_valid, req_a_opa, req_a_opb, req_a_op,
        output req_b_valid, req_b_opa, req_b_opb, req_b_op,
        output hold, fpu_result,
        input  req_a_ready, req_b_ready,
        input  fpu_issue, fpu_opa, fpu_opb, fpu_op,
        input  rsp_a_valid, rsp_b_valid, rsp_data, idle
    );

    modport slave (
        input  req_a_valid, req_a_opa, req_a_opb, req_a_op,
        input  req_b_valid, req_b_opa, req_b_opb, req_b_op,
        input  hold, fpu_result,
        output req_a_ready, req_b_ready,
        output fpu_issue, fpu_opa, fpu_opb, fpu_op,
        output rsp_a_valid, rsp_b_valid, rsp_data, idle
    );

endinterface
`default_nettype wire

// File: rtl/fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_arbiter
//  Description : Round-robin arbiter sharing one fixed-latency FPU between two
//                requesters. Accepted operations are issued one cycle after
//                transfer. A LAT-deep tag pipeline routes each result back to
//                its requester. Per-requester credit counters bound the
//                number of in-flight operations to OUT_MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_arbiter #(
    parameter int LAT     = 3,   // FPU latency, 1..8
    parameter int OUT_MAX = 4    // in-flight limit per requester, 1..15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fpu_issue_arbiter_if.slave bus
);

    localparam logic [3:0] c_OUT_MAX = 4'(OUT_MAX);
    localparam logic [3:0] c_CNT_ONE = 4'd1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic           r_last_b;      // 1: B was served last, so A wins a tie
    logic [3:0]     r_cnt_a;
    logic [3:0]     r_cnt_b;

    logic           r_fpu_issue;
    logic [31:0]    r_fpu_opa;
    logic [31:0]    r_fpu_opb;
    logic           r_fpu_op;
    logic           r_issue_id;    // owner of the op on the FPU inputs (1 = B)

    logic [LAT-1:0] r_tag_vld;     // stage i is valid 2+i cycles after transfer
    logic [LAT-1:0] r_tag_id;

    logic           r_rsp_a_valid;
    logic           r_rsp_b_valid;
    logic [31:0]    r_rsp_data;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic w_elig_a;
    logic w_elig_b;
    logic w_grant_a;
    logic w_grant_b;
    logic w_xfer;
    logic w_exit_vld;
    logic w_exit_id;
    logic w_ret_a;
    logic w_ret_b;

    // Eligibility and round-robin grant; depends only on requests, hold,
    // pointer and credits so ready never waits on the FPU result path.
    always_comb begin
        w_elig_a  = bus.req_a_valid && !bus.hold && (r_cnt_a < c_OUT_MAX);
        w_elig_b  = bus.req_b_valid && !bus.hold && (r_cnt_b < c_OUT_MAX);
        w_grant_a = w_elig_a && (!w_elig_b || r_last_b);
        w_grant_b = w_elig_b && (!w_elig_a || !r_last_b);
        w_xfer    = w_grant_a || w_grant_b;
    end

    // The oldest tag leaves the pipeline in the cycle its result is on
    // fpu_result. Its owner's credit is returned at the same edge that
    // raises the response strobe.
    always_comb begin
        w_exit_vld = r_tag_vld[LAT-1];
        w_exit_id  = r_tag_id[LAT-1];
        w_ret_a    = w_exit_vld && !w_exit_id;
        w_ret_b    = w_exit_vld &&  w_exit_id;
    end

    assign bus.req_a_ready = w_grant_a;
    assign bus.req_b_ready = w_grant_b;

    // Round-robin pointer moves only when an operation is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_b <= 1'b1;
        end else if (w_xfer) begin
            r_last_b <= w_grant_b;
        end
    end

    // Register the accepted operation onto the FPU inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpu_issue <= 1'b0;
            r_fpu_opa   <= 32'd0;
            r_fpu_opb   <= 32'd0;
            r_fpu_op    <= 1'b0;
            r_issue_id  <= 1'b0;
        end else begin
            r_fpu_issue <= w_xfer;
            if (w_grant_a) begin
                r_fpu_opa  <= bus.req_a_opa;
                r_fpu_opb  <= bus.req_a_opb;
                r_fpu_op   <= bus.req_a_op;
                r_issue_id <= 1'b0;
            end else if (w_grant_b) begin
                r_fpu_opa  <= bus.req_b_opa;
                r_fpu_opb  <= bus.req_b_opb;
                r_fpu_op   <= bus.req_b_op;
                r_issue_id <= 1'b1;
            end
        end
    end

    // Tag pipeline follows each issue through the FPU latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            r_tag_vld[0] <= r_fpu_issue;
            r_tag_id[0]  <= r_issue_id;
        end
    end

    // Capture the result as its tag exits; data holds between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_a_valid <= 1'b0;
            r_rsp_b_valid <= 1'b0;
            r_rsp_data    <= 32'd0;
        end else begin
            r_rsp_a_valid <= w_ret_a;
            r_rsp_b_valid <= w_ret_b;
            if (w_exit_vld) begin
                r_rsp_data <= bus.fpu_result;
            end
        end
    end

    // Credit counter for A: take on transfer, return on response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_a <= 4'd0;
        end else begin
            case ({w_grant_a, w_ret_a})
                2'b10:   r_cnt_a <= r_cnt_a + c_CNT_ONE;
                2'b01:   r_cnt_a <= (r_cnt_a != 4'd0) ? r_cnt_a - c_CNT_ONE : r_cnt_a;
                default: r_cnt_a <= r_cnt_a;
            endcase
        end
    end

    // Credit counter for B: take on transfer, return on response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_b <= 4'd0;
        end else begin
            case ({w_grant_b, w_ret_b})
                2'b10:   r_cnt_b <= r_cnt_b + c_CNT_ONE;
                2'b01:   r_cnt_b <= (r_cnt_b != 4'd0) ? r_cnt_b - c_CNT_ONE : r_cnt_b;
                default: r_cnt_b <= r_cnt_b;
            endcase
        end
    end

    assign bus.fpu_issue   = r_fpu_issue;
    assign bus.fpu_opa     = r_fpu_opa;
    assign bus.fpu_opb     = r_fpu_opb;
    assign bus.fpu_op      = r_fpu_op;
    assign bus.rsp_a_valid = r_rsp_a_valid;
    assign bus.rsp_b_valid = r_rsp_b_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.idle        = (r_cnt_a == 4'd0) && (r_cnt_b == 4'd0) &&
                             !r_fpu_issue && !(|r_tag_vld);

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_issue_arbiter
//  Description : Self-checking bench for fpu_issue_arbiter. A timeline model
//                records, per cycle, the expected grants, issues, FPU results
//                and responses, derived from the arbitration and latency
//                rules. Directed phases cover single op, contention, credit
//                limit, hold and mid-flight reset. A random phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_arbiter;

    localparam int LAT     = 3;
    localparam int OUT_MAX = 4;
    localparam int N       = 4096;

    logic clk;
    logic rst;

    fpu_issue_arbiter_if bus ();

    fpu_issue_arbiter #(.LAT(LAT), .OUT_MAX(OUT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Timeline model, indexed by cycle number
    int          cyc;
    bit          e_iss [N];
    logic [31:0] e_opa [N];
    logic [31:0] e_opb [N];
    bit          e_op  [N];
    bit          res_v [N];   // FPU result due on fpu_result this cycle
    logic [31:0] res_d [N];
    bit          e_ra  [N];
    bit          e_rb  [N];
    logic [31:0] e_rd  [N];
    bit          busy  [N];   // issue or tag still in flight
    int          m_cnt_a;
    int          m_cnt_b;
    bit          m_last_b;
    logic [31:0] m_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input bit op);
        return op ? (a - b) : (a + b);
    endfunction

    task automatic clear_future();
        for (int i = cyc; i < cyc + LAT + 6 && i < N; i++) begin
            e_iss[i] = 0; res_v[i] = 0; e_ra[i] = 0; e_rb[i] = 0; busy[i] = 0;
        end
        m_cnt_a  = 0;
        m_cnt_b  = 0;
        m_last_b = 1;
        m_data   = 32'd0;
    endtask

    // Starts and ends at a negedge; holds reset across one posedge
    task automatic do_reset();
        rst = 1'b1;
        bus.req_a_valid = 1'b0;
        bus.req_b_valid = 1'b0;
        bus.hold        = 1'b0;
        #1;
        check_eq("rst_fpu_issue", bus.fpu_issue, 0);
        check_eq("rst_fpu_opa", bus.fpu_opa, 0);
        check_eq("rst_fpu_op", bus.fpu_op, 0);
        check_eq("rst_rsp_a", bus.rsp_a_valid, 0);
        check_eq("rst_rsp_b", bus.rsp_b_valid, 0);
        check_eq("rst_rsp_data", bus.rsp_data, 0);
        check_eq("rst_idle", bus.idle, 1);
        clear_future();
        @(posedge clk);
        cyc++;
        clear_future();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive at negedge, check, advance model, step to next negedge
    task automatic run_cycle(input bit va, input bit vb, input bit h);
        bit          ea;
        bit          eb;
        bit          ga;
        bit          gb;
        logic [31:0] a;
        logic [31:0] b;
        bit          o;
        logic [31:0] r;
        int          t;

        bus.req_a_valid = va;
        bus.req_a_opa   = $urandom;
        bus.req_a_opb   = $urandom;
        bus.req_a_op    = 1'($urandom);
        bus.req_b_valid = vb;
        bus.req_b_opa   = $urandom;
        bus.req_b_opb   = $urandom;
        bus.req_b_op    = 1'($urandom);
        bus.hold        = h;
        bus.fpu_result  = res_v[cyc] ? res_d[cyc] : $urandom;
        #1;

        ea = va && !h && (m_cnt_a < OUT_MAX);
        eb = vb && !h && (m_cnt_b < OUT_MAX);
        ga = ea && (!eb || m_last_b);
        gb = eb && (!ea || !m_last_b);

        check_eq("ready_a", bus.req_a_ready, ga);
        check_eq("ready_b", bus.req_b_ready, gb);
        check_eq("fpu_issue", bus.fpu_issue, e_iss[cyc]);
        if (e_iss[cyc]) begin
            check_eq("fpu_opa", bus.fpu_opa, e_opa[cyc]);
            check_eq("fpu_opb", bus.fpu_opb, e_opb[cyc]);
            check_eq("fpu_op", bus.fpu_op, e_op[cyc]);
        end
        check_eq("rsp_a_valid", bus.rsp_a_valid, e_ra[cyc]);
        check_eq("rsp_b_valid", bus.rsp_b_valid, e_rb[cyc]);
        if (e_ra[cyc] || e_rb[cyc]) m_data = e_rd[cyc];
        check_eq("rsp_data", bus.rsp_data, m_data);
        check_eq("idle", bus.idle, (m_cnt_a == 0 && m_cnt_b == 0 && !busy[cyc]));

        if (ga || gb) begin
            a = ga ? bus.req_a_opa : bus.req_b_opa;
            b = ga ? bus.req_a_opb : bus.req_b_opb;
            o = ga ? bus.req_a_op  : bus.req_b_op;
            r = fpu_fn(a, b, o);
            t = cyc;
            e_iss[t+1] = 1; e_opa[t+1] = a; e_opb[t+1] = b; e_op[t+1] = o;
            for (int k = t + 1; k <= t + 1 + LAT; k++) busy[k] = 1;
            res_v[t+1+LAT] = 1; res_d[t+1+LAT] = r;
            if (ga) e_ra[t+2+LAT] = 1; else e_rb[t+2+LAT] = 1;
            e_rd[t+2+LAT] = r;
            m_last_b = gb;
        end
        // credits are back in the cycle the response strobe appears
        if (ga) m_cnt_a++;
        if (gb) m_cnt_b++;
        if (e_ra[cyc+1]) m_cnt_a--;
        if (e_rb[cyc+1]) m_cnt_b--;

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        rst = 1'b1;
        bus.req_a_valid = 1'b0; bus.req_a_opa = '0; bus.req_a_opb = '0; bus.req_a_op = 1'b0;
        bus.req_b_valid = 1'b0; bus.req_b_opa = '0; bus.req_b_opb = '0; bus.req_b_op = 1'b0;
        bus.hold = 1'b0; bus.fpu_result = '0;
        @(negedge clk);
        do_reset();

        // Single operation from A, then drain
        run_cycle(1, 0, 0);
        repeat (LAT + 4) run_cycle(0, 0, 0);

        // Contention: both valid continuously
        repeat (20) run_cycle(1, 1, 0);
        repeat (LAT + 4) run_cycle(0, 0, 0);

        // Credit limit: B alone
        repeat (30) run_cycle(0, 1, 0);
        repeat (LAT + 4) run_cycle(0, 0, 0);

        // Hold with two in flight, then resume arbitration
        repeat (2) run_cycle(1, 0, 0);
        repeat (5) run_cycle(1, 1, 1);
        repeat (6) run_cycle(1, 1, 0);
        repeat (LAT + 4) run_cycle(0, 0, 0);

        // Reset with three ops in flight; first grant afterwards goes to A
        repeat (3) run_cycle(0, 1, 0);
        do_reset();
        repeat (3) run_cycle(1, 1, 0);
        repeat (LAT + 4) run_cycle(0, 0, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            run_cycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 10) == 0);
            if (i == 250) do_reset();
        end
        repeat (LAT + 6) run_cycle(0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
